rv32_dmem_arbiter: RTL and testbench
====================================

RV32_DMEM_ARBITER -- requirements
Module: rv32_dmem_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 8, meaning number of requesters (harts) sharing one data-memory port.
REQ-002 The block SHALL have parameter AddrWidth, default 13, meaning word-address width of the memory port.
REQ-003 The block SHALL have parameter DataWidth, default 32, meaning data width in bits.
REQ-004 The block SHALL have parameter BeWidth, default 4, meaning byte-enable width (DataWidth/8).
REQ-005 The block SHALL have parameter Latency, default 1, meaning memory read latency in cycles (range 1..4).
REQ-006 The block SHALL have clk_i, input, 1, meaning the single clock; all logic rising-edge.
REQ-007 The block SHALL have rst_ni, input, 1, meaning asynchronous active-low reset.
REQ-008 The block SHALL have req_valid_i, input, NumReq, meaning per-requester request pending.
REQ-009 The block SHALL have req_ready_o, output, NumReq, meaning per-requester request accepted this cycle (one-hot or zero).
REQ-010 The block SHALL have req_we_i / req_addr_i / req_wdata_i / req_be_i, inputs, NumReq x 1 / AddrWidth / DataWidth / BeWidth, meaning per-requester write enable, address, write data, byte enable.
REQ-011 The block SHALL have rsp_valid_o, output, NumReq, meaning per-requester response (one-hot or zero).
REQ-012 The block SHALL have rsp_rdata_o, output, DataWidth, meaning shared response data bus.
REQ-013 The block SHALL have mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_be_o, outputs, 1 / 1 / AddrWidth / DataWidth / BeWidth, meaning one memory port request.
REQ-014 The block SHALL have mem_rdata_i, input, DataWidth, meaning memory read data, valid Latency cycles after mem_req_o.

Function
REQ-015 Arbitration SHALL be round-robin over req_valid_i; the winner is the lowest index >= priority pointer, wrapping modulo NumReq.
REQ-016 Grant SHALL be combinational: req_ready_o[g] and mem_req_o asserted in the same cycle as req_valid_i[g]; mem_we/addr/wdata/be mux requester g's fields.
REQ-017 A request SHALL be transferred when req_valid_i[i] && req_ready_o[i]; at most one transfer per cycle.
REQ-018 After a transfer from g the pointer SHALL become (g+1) mod NumReq; with no valid request the pointer SHALL hold.
REQ-019 With no valid request, mem_req_o SHALL be 0 and mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o SHALL be 0.
REQ-020 A Latency-deep pipeline SHALL carry {valid, index, we} for each transfer; the response fires exactly Latency cycles after the transfer.
REQ-021 Every transfer (read or write) SHALL produce exactly one rsp_valid_o[index] pulse of one cycle.
REQ-022 rsp_rdata_o SHALL equal mem_rdata_i for read responses and 0 for write responses and idle cycles.
REQ-023 Back-to-back transfers every cycle SHALL be supported with no bubble; pipeline never stalls.
REQ-024 A requester SHALL be re-grantable in the cycle its own response is returned.
REQ-025 A single active requester SHALL be granted every cycle regardless of pointer position.
REQ-026 Requester payload changes while not granted SHALL have no effect.

Reset
REQ-027 On rst_ni low, pointer SHALL be 0 and all pipeline valid bits 0, asynchronously.
REQ-028 During reset, req_ready_o, mem_req_o and rsp_valid_o SHALL be 0.
REQ-029 Transfers in flight at reset assertion SHALL be discarded; no responses after reset release.
REQ-030 The first cycle after release SHALL arbitrate from index 0.

Structure
REQ-031 Package rv32_dmem_pkg SHALL hold the pipeline-entry struct type {valid, idx, we}, the default NumReq and AddrWidth constants.
REQ-032 A sub-module rv32_rr_arbiter (request vector, pointer in, one-hot grant and index out, combinational) SHALL implement REQ-015.
REQ-033 The pointer register and response pipeline SHALL reside in rv32_dmem_arbiter.

Verification
REQ-034 All 8 requesters valid for 16 cycles from reset -> grants 0,1,...,7,0,...,7 in order, one per cycle, responses to same order 1 cycle later.
REQ-035 Requester 3 writes 0xDEADBEEF addr 0x10 be 0xF, then requester 5 reads addr 0x10 -> rsp_valid_o[3] with rdata 0, then rsp_valid_o[5] with rdata 0xDEADBEEF.
REQ-036 Only requester 6 valid for 5 cycles -> granted all 5 cycles, pointer ends 7, 5 responses.
REQ-037 Requesters 2 and 5 valid, pointer 4 -> 5 granted first, then 2.
REQ-038 Latency=2, reset asserted one cycle after a read grant to requester 1 -> no rsp_valid_o pulse; first post-reset grant goes to lowest valid index.
REQ-039 No requests for 10 cycles -> mem_req_o=0, rsp_valid_o=0, rsp_rdata_o=0, pointer unchanged.

Source files
------------

// File: rtl/rv32_dmem_pkg.sv
// rtl/rv32_dmem_pkg.sv - shared types and defaults for the data-memory arbiter
package rv32_dmem_pkg;

    localparam int unsigned NumReqDefault    = 8;
    localparam int unsigned AddrWidthDefault = 13;
    localparam int unsigned IdxWidthMax      = 8;

    // One in-flight transfer travelling down the response pipeline.
    typedef struct packed {
        logic                   valid;
        logic [IdxWidthMax-1:0] idx;
        logic                   we;
    } pipe_entry_t;

endpackage

// File: rtl/rv32_rr_arbiter.sv
// rtl/rv32_rr_arbiter.sv - combinational round-robin pick: lowest index at or above the pointer
module rv32_rr_arbiter
    import rv32_dmem_pkg::*;
#(
    parameter int unsigned NumReq = NumReqDefault,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rv32_dmem_arbiter.sv
// rtl/rv32_dmem_arbiter.sv - round-robin sharing of one data-memory port with a fixed-latency response pipe
module rv32_dmem_arbiter
    import rv32_dmem_pkg::*;
#(
    parameter int unsigned NumReq    = NumReqDefault,
    parameter int unsigned AddrWidth = AddrWidthDefault,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = 4,
    parameter int unsigned Latency   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0]                   req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]      req_be_i,
    output logic [NumReq-1:0]                   rsp_valid_o,
    output logic [DataWidth-1:0]                rsp_rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [BeWidth-1:0]                  mem_be_o,
    input  logic [DataWidth-1:0]                mem_rdata_i
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [NumReq-1:0] arb_req;
    logic [NumReq-1:0] gnt;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_valid;
    pipe_entry_t       entry_in;
    pipe_entry_t       rsp_e;
    pipe_entry_t       pipe_q [Latency];

    // Masking with reset keeps grants and memory requests quiet while held in reset.
    assign arb_req = req_valid_i & {NumReq{rst_ni}};

    rv32_rr_arbiter #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arbiter (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    always_comb begin
        req_ready_o = gnt;
        mem_req_o   = gnt_valid;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        ptr_d       = ptr_q;
        if (gnt_valid) begin
            mem_we_o    = req_we_i[gnt_idx];
            mem_addr_o  = req_addr_i[gnt_idx];
            mem_wdata_o = req_wdata_i[gnt_idx];
            mem_be_o    = req_be_i[gnt_idx];
            ptr_d       = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
        end
        entry_in.valid = gnt_valid;
        entry_in.idx   = IdxWidthMax'(gnt_idx);
        entry_in.we    = mem_we_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            pipe_q[0] <= entry_in;
            for (int i = 1; i < Latency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rsp_e = pipe_q[Latency-1];

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            rsp_valid_o[i] = rsp_e.valid && (rsp_e.idx == IdxWidthMax'(i));
        end
        rsp_rdata_o = (rsp_e.valid && !rsp_e.we) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// tb/tb_rv32_dmem_arbiter.sv - directed table-driven bench for the data-memory arbiter
module tb_rv32_dmem_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rst2_n;
    logic [7:0]        valid;
    logic [7:0]        valid2;
    logic [7:0]        we;
    logic [7:0][12:0]  addr;
    logic [7:0][31:0]  wdata;
    logic [7:0][3:0]   be;
    logic [31:0]       mem_rdata = 32'h0;
    logic [31:0]       wr10 = 32'h0;
    logic [31:0]       zero32 = 32'h0;

    logic [7:0]  ready, rsp_valid;
    logic [31:0] rsp_rdata, mem_wdata;
    logic        mem_req, mem_we;
    logic [12:0] mem_addr;
    logic [3:0]  mem_be;

    logic [7:0]  ready2, rsp_valid2;
    logic [31:0] rsp_rdata2, mem_wdata2;
    logic        mem_req2, mem_we2;
    logic [12:0] mem_addr2;
    logic [3:0]  mem_be2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32_dmem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(ready),
        .req_we_i(we), .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    rv32_dmem_arbiter #(.Latency(2)) dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .req_valid_i(valid2), .req_ready_o(ready2),
        .req_we_i(we), .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
        .rsp_valid_o(rsp_valid2), .rsp_rdata_o(rsp_rdata2), .mem_req_o(mem_req2),
        .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2),
        .mem_be_o(mem_be2), .mem_rdata_i(zero32)
    );

    // Memory: word 0x10 is writable, every other word reads as A5A5_<addr>.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                if (mem_addr == 13'h10) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) wr10[8*b +: 8] <= mem_wdata[8*b +: 8];
                    end
                end
            end else begin
                mem_rdata <= (mem_addr == 13'h10) ? wr10 : {16'hA5A5, 3'b000, mem_addr};
            end
        end
    end

    typedef struct {
        logic [7:0]  v;
        logic [7:0]  rdy;
        logic [7:0]  rsp;
        logic [31:0] rdata;
    } vec_t;

    vec_t       tbl [$];
    logic [7:0] prev_rdy = 8'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [7:0] oh);
        int r = 0;
        for (int i = 0; i < 8; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic add(input logic [7:0] v, input logic [7:0] rdy);
        vec_t e;
        e.v     = v;
        e.rdy   = rdy;
        e.rsp   = prev_rdy;
        e.rdata = (prev_rdy != 0) ? (32'hA5A5_0000 | 32'(idx_of(prev_rdy))) : 32'h0;
        tbl.push_back(e);
        prev_rdy = rdy;
    endtask

    initial begin
        int g;
        for (int i = 0; i < 8; i++) begin
            we[i]    = 1'b0;
            addr[i]  = 13'(i);
            wdata[i] = 32'h1000_0000 + 32'(i);
            be[i]    = 4'hF;
        end
        rst_n = 1'b0; rst2_n = 1'b0;
        valid = 8'hFF; valid2 = 8'hFF;

        // All requesters from reset: strict 0..7 rotation twice.
        for (int i = 0; i < 16; i++) add(8'hFF, 8'(1 << (i % 8)));
        // Lone requester 6 is granted every cycle; pointer ends at 7.
        for (int i = 0; i < 5; i++) add(8'h40, 8'h40);
        // Idle for 10 cycles; pointer must still be 7.
        for (int i = 0; i < 10; i++) add(8'h00, 8'h00);
        add(8'h81, 8'h80);
        add(8'h81, 8'h01);
        // Park pointer at 4, then 2 and 5 contend.
        add(8'h08, 8'h08);
        add(8'h24, 8'h20);
        add(8'h24, 8'h04);
        add(8'h00, 8'h00);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_rsp", 32'(rsp_valid), 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        valid = 8'h00; valid2 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            @(negedge clk);
            chk($sformatf("row%0d_rsp", n), 32'(rsp_valid), 32'(tbl[n].rsp));
            chk($sformatf("row%0d_rdata", n), rsp_rdata, tbl[n].rdata);
            valid = tbl[n].v;
            #1;
            g = idx_of(tbl[n].rdy);
            chk($sformatf("row%0d_ready", n), 32'(ready), 32'(tbl[n].rdy));
            chk($sformatf("row%0d_mem_req", n), 32'(mem_req), 32'(tbl[n].rdy != 0));
            chk($sformatf("row%0d_mem_we", n), 32'(mem_we), 32'h0);
            chk($sformatf("row%0d_mem_addr", n), 32'(mem_addr), (tbl[n].rdy != 0) ? 32'(g) : 32'h0);
            chk($sformatf("row%0d_mem_wdata", n), mem_wdata, (tbl[n].rdy != 0) ? 32'h1000_0000 + 32'(g) : 32'h0);
            chk($sformatf("row%0d_mem_be", n), 32'(mem_be), (tbl[n].rdy != 0) ? 32'hF : 32'h0);
        end

        // Requester 3 writes 0x10, requester 5 reads it back.
        @(negedge clk);
        chk("wr_pre_rsp", 32'(rsp_valid), 32'h0);
        we[3] = 1'b1; addr[3] = 13'h10; wdata[3] = 32'hDEAD_BEEF; valid = 8'h08;
        #1;
        chk("wr_ready", 32'(ready), 32'h08);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_rsp", 32'(rsp_valid), 32'h08);
        chk("wr_rdata", rsp_rdata, 32'h0);
        we[3] = 1'b0; addr[5] = 13'h10; valid = 8'h20;
        #1;
        chk("rd_ready", 32'(ready), 32'h20);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        chk("rd_rsp", 32'(rsp_valid), 32'h20);
        chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        valid = 8'h00;

        // Latency-2 instance: reset kills an in-flight read to requester 1.
        rst2_n = 1'b1;
        @(negedge clk);
        valid2 = 8'h02;
        #1;
        chk("l2_gnt1", 32'(ready2), 32'h02);
        @(negedge clk);
        valid2 = 8'h00;
        rst2_n = 1'b0;
        #1;
        chk("l2_rst_ready", 32'(ready2), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("l2_rst_rsp%0d", i), 32'(rsp_valid2), 32'h0);
        end
        valid2 = 8'h0C;
        rst2_n = 1'b1;
        #1;
        chk("l2_first_gnt", 32'(ready2), 32'h04);
        @(negedge clk);
        valid2 = 8'h00;
        chk("l2_post_rsp0", 32'(rsp_valid2), 32'h0);
        @(negedge clk);
        chk("l2_post_rsp1", 32'(rsp_valid2), 32'h04);
        @(negedge clk);
        chk("l2_post_rsp2", 32'(rsp_valid2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
